// File: rtl/asrv32_stage_seq_pkg.sv
// Shared constants and stage encoding for the asrv32 multi-cycle stage sequencer.
// Stages are one-hot so the state register doubles as the o_stage_q output.
package asrv32_stage_seq_pkg;

   localparam int STAGE_W = 6;

   localparam logic [STAGE_W-1:0] STAGE_FETCH = 6'b000001;
   localparam logic [STAGE_W-1:0] STAGE_DEC   = 6'b000010;
   localparam logic [STAGE_W-1:0] STAGE_EXE   = 6'b000100;
   localparam logic [STAGE_W-1:0] STAGE_MEM   = 6'b001000;
   localparam logic [STAGE_W-1:0] STAGE_WB    = 6'b010000;
   localparam logic [STAGE_W-1:0] STAGE_TRAP  = 6'b100000;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [1:0] TRAP_FETCH = 2'd0;
   localparam logic [1:0] TRAP_DATA  = 2'd1;

   typedef enum logic [STAGE_W-1:0] {
      ST_FETCH = STAGE_FETCH,
      ST_DEC   = STAGE_DEC,
      ST_EXE   = STAGE_EXE,
      ST_MEM   = STAGE_MEM,
      ST_WB    = STAGE_WB,
      ST_TRAP  = STAGE_TRAP
   } stage_e;

endpackage

// File: rtl/asrv32_stage_seq_wait_timer.sv
// Wait-state counter shared by the fetch and data handshakes.
// Expires in the cycle that would be the TIMEOUT_CYCLES-th unacknowledged wait.
module asrv32_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] r_count;

   // Clear has priority so a fresh wait always starts counting from zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CW'(1);
      end
   end

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_noTimeout
         assign o_expire = 1'b0;
      end else begin : g_timeout
         assign o_expire = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/asrv32_stage_seq.sv
// Fetch/decode/execute/memory/writeback sequencer for the multi-cycle asrv32 core,
// with ack-based memory handshakes, ALU stall, optional MEM skip and a bus-timeout trap.
module asrv32_stage_seq
   import asrv32_stage_seq_pkg::*;
#(
   parameter logic [31:0] PC_RESET       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter int          SKIP_MEM       = 1,
   parameter int          CNT_W          = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [31:0]        i_pc,
   output logic               o_imem_req,
   output logic [31:0]        o_imem_addr,
   input  logic               i_imem_ack,
   input  logic [31:0]        i_imem_rdata,
   output logic [31:0]        o_inst_q,
   input  logic               i_is_mem,
   input  logic               i_alu_busy,
   output logic               o_dmem_req,
   input  logic               i_dmem_ack,
   output logic               o_alu_en,
   output logic               o_mem_en,
   output logic               o_wb_en,
   output logic [STAGE_W-1:0] o_stage_q,
   output logic               o_trap,
   output logic [1:0]         o_trap_stage,
   output logic [CNT_W-1:0]   o_retire_cnt
);

   stage_e           r_state;
   stage_e           w_next;
   logic             r_imemReq;
   logic             r_dmemReq;
   logic [31:0]      r_imemAddr;
   logic [31:0]      r_inst;
   logic             r_trap;
   logic [1:0]       r_trapStage;
   logic [CNT_W-1:0] r_retire;

   logic w_fetchAck;
   logic w_dataAck;
   logic w_waitPending;
   logic w_timerClear;
   logic w_expire;

   // Acks only count while our own request is outstanding; anything else is spurious.
   assign w_fetchAck    = (r_state == ST_FETCH) && r_imemReq && i_imem_ack;
   assign w_dataAck     = (r_state == ST_MEM) && r_dmemReq && i_dmem_ack;
   assign w_waitPending = ((r_state == ST_FETCH) && r_imemReq && !i_imem_ack) ||
                          ((r_state == ST_MEM) && r_dmemReq && !i_dmem_ack);
   assign w_timerClear  = (w_next != r_state);

   asrv32_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_waitTimer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_timerClear),
      .i_enable(w_waitPending),
      .o_expire(w_expire)
   );

   // Next-stage selection; an ack in the expiry cycle is checked first so it wins.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (w_fetchAck) begin
               w_next = ST_DEC;
            end else if (w_expire) begin
               w_next = ST_TRAP;
            end
         end
         ST_DEC: w_next = ST_EXE;
         ST_EXE: begin
            if (!i_alu_busy) begin
               w_next = (i_is_mem || (SKIP_MEM == 0)) ? ST_MEM : ST_WB;
            end
         end
         ST_MEM: begin
            if (!r_dmemReq || w_dataAck) begin
               w_next = ST_WB;
            end else if (w_expire) begin
               w_next = ST_TRAP;
            end
         end
         ST_WB:   w_next = ST_FETCH;
         ST_TRAP: w_next = ST_TRAP;
         default: w_next = ST_FETCH;
      endcase
   end

   // Requests are registered from the next stage so they rise on stage entry,
   // which lets a zero-wait memory ack in the very first FETCH/MEM cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_FETCH;
         r_imemReq   <= 1'b0;
         r_dmemReq   <= 1'b0;
         r_imemAddr  <= PC_RESET;
         r_inst      <= NOP_INST;
         r_trap      <= 1'b0;
         r_trapStage <= TRAP_FETCH;
         r_retire    <= '0;
      end else begin
         r_state   <= w_next;
         r_imemReq <= (w_next == ST_FETCH);
         r_dmemReq <= (w_next == ST_MEM) && i_is_mem;
         if ((w_next == ST_FETCH) && !r_imemReq) begin
            r_imemAddr <= i_pc;
         end
         if (w_fetchAck) begin
            r_inst <= i_imem_rdata;
         end
         if (r_state == ST_WB) begin
            r_retire <= r_retire + CNT_W'(1);
         end
         if ((w_next == ST_TRAP) && (r_state != ST_TRAP)) begin
            r_trap      <= 1'b1;
            r_trapStage <= (r_state == ST_MEM) ? TRAP_DATA : TRAP_FETCH;
         end
      end
   end

   assign o_imem_req   = r_imemReq;
   assign o_imem_addr  = r_imemAddr;
   assign o_inst_q     = r_inst;
   assign o_dmem_req   = r_dmemReq;
   assign o_alu_en     = (r_state == ST_EXE);
   assign o_mem_en     = (r_state == ST_MEM);
   assign o_wb_en      = (r_state == ST_WB);
   assign o_stage_q    = r_state;
   assign o_trap       = r_trap;
   assign o_trap_stage = r_trapStage;
   assign o_retire_cnt = r_retire;

endmodule

// File: tb/tb_asrv32_stage_seq.sv
// Directed bench for asrv32_stage_seq: one SKIP_MEM=1 instance (short timeout, 4-bit
// retire counter) driven through every scenario, plus a SKIP_MEM=0 instance sharing stimulus.
module tb_asrv32_stage_seq;

   localparam logic [31:0] PC0 = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        imemAck;
   logic [31:0] imemRdata;
   logic        isMem;
   logic        aluBusy;
   logic        dmemAck;

   logic        imemReq, dmemReq, aluEn, memEn, wbEn, trap;
   logic [31:0] imemAddr, instQ;
   logic [5:0]  stageQ;
   logic [1:0]  trapStage;
   logic [3:0]  retireCnt;

   logic        nsImemReq, nsDmemReq, nsAluEn, nsMemEn, nsWbEn, nsTrap;
   logic [31:0] nsImemAddr, nsInstQ;
   logic [5:0]  nsStageQ;
   logic [1:0]  nsTrapStage;
   logic [31:0] nsRetireCnt;

   int checkCount = 0;
   int errCount   = 0;

   asrv32_stage_seq #(
      .PC_RESET(PC0), .TIMEOUT_CYCLES(4), .SKIP_MEM(1), .CNT_W(4)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pc(pc),
      .o_imem_req(imemReq), .o_imem_addr(imemAddr), .i_imem_ack(imemAck),
      .i_imem_rdata(imemRdata), .o_inst_q(instQ), .i_is_mem(isMem),
      .i_alu_busy(aluBusy), .o_dmem_req(dmemReq), .i_dmem_ack(dmemAck),
      .o_alu_en(aluEn), .o_mem_en(memEn), .o_wb_en(wbEn), .o_stage_q(stageQ),
      .o_trap(trap), .o_trap_stage(trapStage), .o_retire_cnt(retireCnt)
   );

   asrv32_stage_seq #(
      .PC_RESET(PC0), .TIMEOUT_CYCLES(4), .SKIP_MEM(0), .CNT_W(32)
   ) dutNoSkip (
      .i_clk(clk), .i_rst(rst), .i_pc(pc),
      .o_imem_req(nsImemReq), .o_imem_addr(nsImemAddr), .i_imem_ack(imemAck),
      .i_imem_rdata(imemRdata), .o_inst_q(nsInstQ), .i_is_mem(isMem),
      .i_alu_busy(aluBusy), .o_dmem_req(nsDmemReq), .i_dmem_ack(dmemAck),
      .o_alu_en(nsAluEn), .o_mem_en(nsMemEn), .o_wb_en(nsWbEn), .o_stage_q(nsStageQ),
      .o_trap(nsTrap), .o_trap_stage(nsTrapStage), .o_retire_cnt(nsRetireCnt)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic rstV, input logic [31:0] pcV, input logic ackV,
                                input logic [31:0] rdataV, input logic isMemV,
                                input logic busyV, input logic dackV);
      rst       = rstV;
      pc        = pcV;
      imemAck   = ackV;
      imemRdata = rdataV;
      isMem     = isMemV;
      aluBusy   = busyV;
      dmemAck   = dackV;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one clock and sample 1 unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed scenario sequence; expected values are hand-derived cycle by cycle.
   initial begin
      applyStimulus(1'b1, PC0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst stage", 32'(stageQ), 32'h01);
      checkOutput("rst inst", instQ, 32'h0000_0013);
      checkOutput("rst addr", imemAddr, PC0);
      checkOutput("rst imemReq", 32'(imemReq), 32'h0);
      checkOutput("rst dmemReq", 32'(dmemReq), 32'h0);
      checkOutput("rst trap", 32'(trap), 32'h0);
      checkOutput("rst trapStage", 32'(trapStage), 32'h0);
      checkOutput("rst retire", 32'(retireCnt), 32'h0);
      checkOutput("rst aluEn", 32'(aluEn), 32'h0);

      $display("[TB] zero-wait ALU instruction");
      applyStimulus(1'b0, PC0, 1'b1, 32'h0020_8133, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("alu c1 stage", 32'(stageQ), 32'h01);
      checkOutput("alu c1 imemReq", 32'(imemReq), 32'h1);
      checkOutput("alu c1 addr", imemAddr, PC0);
      tick();
      checkOutput("alu c2 stage", 32'(stageQ), 32'h02);
      checkOutput("alu c2 inst", instQ, 32'h0020_8133);
      checkOutput("alu c2 imemReq", 32'(imemReq), 32'h0);
      tick();
      checkOutput("alu c3 stage", 32'(stageQ), 32'h04);
      checkOutput("alu c3 aluEn", 32'(aluEn), 32'h1);
      checkOutput("alu c3 dmemReq", 32'(dmemReq), 32'h0);
      pc = PC0 + 32'd4;
      tick();
      checkOutput("alu c4 stage", 32'(stageQ), 32'h10);
      checkOutput("alu c4 wbEn", 32'(wbEn), 32'h1);
      checkOutput("alu c4 dmemReq", 32'(dmemReq), 32'h0);
      checkOutput("alu c4 retire", 32'(retireCnt), 32'h0);
      tick();
      checkOutput("alu next stage", 32'(stageQ), 32'h01);
      checkOutput("alu retire", 32'(retireCnt), 32'h1);
      checkOutput("alu next addr", imemAddr, PC0 + 32'd4);
      checkOutput("alu next imemReq", 32'(imemReq), 32'h1);

      $display("[TB] load with 3 data wait cycles, ack in expiry cycle");
      applyStimulus(1'b0, PC0 + 32'd4, 1'b1, 32'h0001_2083, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("ld dec stage", 32'(stageQ), 32'h02);
      tick();
      checkOutput("ld exe stage", 32'(stageQ), 32'h04);
      tick();
      checkOutput("ld mem1 stage", 32'(stageQ), 32'h08);
      checkOutput("ld mem1 memEn", 32'(memEn), 32'h1);
      checkOutput("ld mem1 dmemReq", 32'(dmemReq), 32'h1);
      tick();
      checkOutput("ld mem2 dmemReq", 32'(dmemReq), 32'h1);
      tick();
      checkOutput("ld mem3 dmemReq", 32'(dmemReq), 32'h1);
      tick();
      checkOutput("ld mem4 dmemReq", 32'(dmemReq), 32'h1);
      checkOutput("ld mem4 stage", 32'(stageQ), 32'h08);
      dmemAck = 1'b1;
      pc = PC0 + 32'd8;
      tick();
      checkOutput("ld wb stage", 32'(stageQ), 32'h10);
      checkOutput("ld wb dmemReq", 32'(dmemReq), 32'h0);
      checkOutput("ld no trap", 32'(trap), 32'h0);
      dmemAck = 1'b0;
      tick();
      checkOutput("ld retire", 32'(retireCnt), 32'h2);
      checkOutput("ld next addr", imemAddr, PC0 + 32'd8);

      $display("[TB] ALU busy for 5 cycles");
      applyStimulus(1'b0, PC0 + 32'd8, 1'b1, 32'h0220_8133, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("busy dec stage", 32'(stageQ), 32'h02);
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("busy exe%0d aluEn", i + 1), 32'(aluEn), 32'h1);
         tick();
      end
      checkOutput("busy exe6 aluEn", 32'(aluEn), 32'h1);
      aluBusy = 1'b0;
      tick();
      checkOutput("busy wb stage", 32'(stageQ), 32'h10);
      checkOutput("busy no trap", 32'(trap), 32'h0);
      tick();
      checkOutput("busy retire", 32'(retireCnt), 32'h3);

      $display("[TB] retire counter wrap");
      applyStimulus(1'b0, PC0 + 32'd12, 1'b1, 32'h0020_8133, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 14; n++) begin
         tick();
         tick();
         tick();
         tick();
         if (n == 12) begin
            checkOutput("wrap to zero", 32'(retireCnt), 32'h0);
         end
      end
      checkOutput("wrap 17 retire", 32'(retireCnt), 32'h1);
      checkOutput("wrap stage", 32'(stageQ), 32'h01);

      $display("[TB] fetch ack in expiry cycle");
      applyStimulus(1'b0, PC0 + 32'd12, 1'b0, 32'h0030_8193, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("fexp c4 stage", 32'(stageQ), 32'h01);
      checkOutput("fexp c4 imemReq", 32'(imemReq), 32'h1);
      imemAck = 1'b1;
      tick();
      checkOutput("fexp dec stage", 32'(stageQ), 32'h02);
      checkOutput("fexp no trap", 32'(trap), 32'h0);
      checkOutput("fexp inst", instQ, 32'h0030_8193);
      tick();
      tick();
      tick();
      checkOutput("fexp retire", 32'(retireCnt), 32'h2);

      $display("[TB] fetch timeout");
      imemAck = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("tmo c4 stage", 32'(stageQ), 32'h01);
      checkOutput("tmo c4 trap", 32'(trap), 32'h0);
      tick();
      checkOutput("tmo stage", 32'(stageQ), 32'h20);
      checkOutput("tmo trap", 32'(trap), 32'h1);
      checkOutput("tmo trapStage", 32'(trapStage), 32'h0);
      checkOutput("tmo imemReq", 32'(imemReq), 32'h0);
      imemAck = 1'b1;
      dmemAck = 1'b1;
      tick();
      tick();
      checkOutput("trap hold stage", 32'(stageQ), 32'h20);
      checkOutput("trap hold imemReq", 32'(imemReq), 32'h0);
      checkOutput("trap hold dmemReq", 32'(dmemReq), 32'h0);
      checkOutput("trap hold aluEn", 32'(aluEn), 32'h0);
      checkOutput("trap hold wbEn", 32'(wbEn), 32'h0);
      checkOutput("trap hold retire", 32'(retireCnt), 32'h2);
      checkOutput("trap hold inst", instQ, 32'h0030_8193);

      $display("[TB] reset during MEM");
      applyStimulus(1'b1, PC0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, PC0, 1'b1, 32'h0001_2083, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      tick();
      checkOutput("rmem dmemReq before", 32'(dmemReq), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rmem dmemReq", 32'(dmemReq), 32'h0);
      checkOutput("rmem stage", 32'(stageQ), 32'h01);
      checkOutput("rmem inst", instQ, 32'h0000_0013);
      checkOutput("rmem retire", 32'(retireCnt), 32'h0);
      checkOutput("rmem memEn", 32'(memEn), 32'h0);
      checkOutput("rmem trap", 32'(trap), 32'h0);
      tick();

      $display("[TB] SKIP_MEM=0 non-mem instruction");
      applyStimulus(1'b0, PC0, 1'b1, 32'h0020_8133, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ns c1 stage", 32'(nsStageQ), 32'h01);
      tick();
      checkOutput("ns c2 stage", 32'(nsStageQ), 32'h02);
      tick();
      checkOutput("ns c3 aluEn", 32'(nsAluEn), 32'h1);
      tick();
      checkOutput("ns c4 stage", 32'(nsStageQ), 32'h08);
      checkOutput("ns c4 memEn", 32'(nsMemEn), 32'h1);
      checkOutput("ns c4 dmemReq", 32'(nsDmemReq), 32'h0);
      checkOutput("skip c4 stage", 32'(stageQ), 32'h10);
      tick();
      checkOutput("ns c5 wbEn", 32'(nsWbEn), 32'h1);
      checkOutput("ns c5 memEn", 32'(nsMemEn), 32'h0);
      tick();
      checkOutput("ns retire", nsRetireCnt, 32'h1);
      checkOutput("ns next stage", 32'(nsStageQ), 32'h01);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
